// File: rtl/aes_shift_rows_if.sv
// Handshake/data bundle for the AES ShiftRows stage.
// The master side presents a state and a direction. The slave side returns
// the permuted state one clock later.
interface aes_shift_rows_if;
   logic         in_valid;
   logic         inverse;
   logic [127:0] state_in;
   logic         out_valid;
   logic [127:0] state_out;

   modport master (
      output in_valid,
      output inverse,
      output state_in,
      input  out_valid,
      input  state_out
   );

   modport slave (
      input  in_valid,
      input  inverse,
      input  state_in,
      output out_valid,
      output state_out
   );
endinterface

// File: rtl/aes_shift_rows.sv
// AES ShiftRows / InvShiftRows stage.
// The stage is a fixed byte permutation of the 128-bit state. A single
// register follows it, so the latency is one clock and a new state can be
// accepted every clock.
// Byte k occupies bits [127-8k -: 8]. The state is column-major, so
// s[r][c] is byte 4c+r.
module aes_shift_rows (
   input  logic              clk,
   input  logic              rst,
   aes_shift_rows_if.slave   bus
);

   // Forward wiring. Row r rotates left by r, so out s[r][c] = in s[r][(c+r) mod 4].
   function automatic logic [127:0] shift_rows_fwd(input logic [127:0] s);
      logic [127:0] p;
      p = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            p[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return p;
   endfunction

   // Inverse wiring. Row r rotates right by r, so out s[r][c] = in s[r][(c-r) mod 4].
   function automatic logic [127:0] shift_rows_inv(input logic [127:0] s);
      logic [127:0] p;
      p = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            p[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
         end
      end
      return p;
   endfunction

   logic [127:0] fwd_perm;
   logic [127:0] inv_perm;
   logic         use_inverse;
   logic [127:0] permuted;
   logic [127:0] state_q;
   logic         valid_q;

   assign fwd_perm = shift_rows_fwd(bus.state_in);
   assign inv_perm = shift_rows_inv(bus.state_in);

   // Select the direction. inverse only matters on a valid cycle, so an idle
   // X on it cannot reach the mux select.
   always_comb begin
      // NOTE: assign every always_comb output first on every path. A path that
      // leaves a signal unassigned infers a latch.
      use_inverse = 1'b0;
      permuted    = fwd_perm;
      use_inverse = bus.in_valid & bus.inverse;
      if (use_inverse) begin
         permuted = inv_perm;
      end
   end

   // Output register. It captures on in_valid, holds its value when idle, and
   // reset takes priority over a concurrent input.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // its pre-edge values. The reset is synchronous and clears only the
      // datapath register, because there is no memory array here.
      if (rst) begin
         state_q <= '0;
         valid_q <= 1'b0;
      end else if (bus.in_valid) begin
         state_q <= permuted;
         valid_q <= 1'b1;
      end else begin
         valid_q <= 1'b0;
      end
   end

   assign bus.state_out = state_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_aes_shift_rows.sv
// Self-checking bench for aes_shift_rows.
// A queue holds expected results. Each one is pushed when its stimulus is
// driven and popped when the registered output appears one clock later.
// The reference model uses the explicit byte maps, not row/column arithmetic.
module tb_aes_shift_rows;

   logic clk;
   logic rst;
   aes_shift_rows_if bus ();

   aes_shift_rows dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;
   logic [127:0] exp_q [$];

   // out byte k <- in byte map[k]
   int fwd_map [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
   int inv_map [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

   logic [127:0] fwd_in  [3] = '{128'hd42711aee0bf98f1b8b45de51e415230,
                                 128'h49ded28945db96f17f39871a7702533b,
                                 128'hac73cf7befc111df13b5d6b545235ab8};
   logic [127:0] fwd_out [3] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5,
                                 128'h49db873b453953897f02d2f177de961a,
                                 128'hacc1d6b8efb55a7b1323cfdf457311b5};

   function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
      logic [127:0] p;
      int src;
      p = '0;
      for (int k = 0; k < 16; k++) begin
         src = inv ? inv_map[k] : fwd_map[k];
         p[127-8*k -: 8] = s[127-8*src -: 8];
      end
      return p;
   endfunction

   // Apply inputs on the falling edge so they are stable at the next rising edge.
   task automatic drive(input logic r, input logic v, input logic inv, input logic [127:0] d);
      @(negedge clk);
      rst          = r;
      bus.in_valid = v;
      bus.inverse  = inv;
      bus.state_in = d;
   endtask

   task automatic sample();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 1'b0, fwd_in[0]);
      sample();
      total++;
      if (bus.state_out !== 128'h0) begin
         bad++;
         $display("FAIL reset_state: got %h want %h", bus.state_out, 128'h0);
      end
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_valid: got %b want 0", bus.out_valid);
      end
      // Release reset and check the first transfer.
      drive(1'b0, 1'b1, 1'b0, fwd_in[0]);
      exp_q.push_back(fwd_out[0]);
      sample();
      total++;
      if (bus.out_valid !== 1'b1 || exp_q.size() == 0 || bus.state_out !== exp_q[0]) begin
         bad++;
         $display("FAIL reset_release: got v=%b %h want v=1 %h", bus.out_valid, bus.state_out, fwd_out[0]);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      // A transfer accepted just before reset still pulses. Reset on the next
      // edge then clears the output and drops the concurrent input.
      drive(1'b0, 1'b1, 1'b0, fwd_in[1]);
      exp_q.push_back(fwd_out[1]);
      sample();
      total++;
      if (bus.out_valid !== 1'b1 || bus.state_out !== exp_q[0]) begin
         bad++;
         $display("FAIL pre_reset_pulse: got v=%b %h want v=1 %h", bus.out_valid, bus.state_out, exp_q[0]);
      end
      void'(exp_q.pop_front());
      drive(1'b1, 1'b1, 1'b1, fwd_in[2]);
      sample();
      total++;
      if (bus.out_valid !== 1'b0 || bus.state_out !== 128'h0) begin
         bad++;
         $display("FAIL reset_drops_input: got v=%b %h want v=0 0", bus.out_valid, bus.state_out);
      end
      drive(1'b0, 1'b0, 1'b0, '0);
      sample();
   endtask

   task automatic test_forward();
      logic [127:0] e;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b0, fwd_in[i]);
         exp_q.push_back(fwd_out[i]);
         sample();
         e = exp_q.pop_front();
         total++;
         if (bus.out_valid !== 1'b1 || bus.state_out !== e) begin
            bad++;
            $display("FAIL forward_%0d: got v=%b %h want v=1 %h", i, bus.out_valid, bus.state_out, e);
         end
      end
   endtask

   task automatic test_inverse();
      logic [127:0] e;
      logic [127:0] vin [2];
      logic [127:0] vout[2];
      vin[0]  = fwd_out[0];
      vout[0] = fwd_in[0];
      vin[1]  = fwd_out[2];
      vout[1] = fwd_in[2];
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 1'b1, vin[i]);
         exp_q.push_back(vout[i]);
         sample();
         e = exp_q.pop_front();
         total++;
         if (bus.out_valid !== 1'b1 || bus.state_out !== e) begin
            bad++;
            $display("FAIL inverse_%0d: got v=%b %h want v=1 %h", i, bus.out_valid, bus.state_out, e);
         end
      end
   endtask

   task automatic test_byte_walk();
      logic [127:0] e;
      drive(1'b0, 1'b1, 1'b0, 128'h000102030405060708090a0b0c0d0e0f);
      exp_q.push_back(128'h00050a0f04090e03080d02070c01060b);
      sample();
      e = exp_q.pop_front();
      total++;
      if (bus.out_valid !== 1'b1 || bus.state_out !== e) begin
         bad++;
         $display("FAIL walk_forward: got v=%b %h want v=1 %h", bus.out_valid, bus.state_out, e);
      end
      drive(1'b0, 1'b1, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);
      exp_q.push_back(128'h000d0a0704010e0b0805020f0c090603);
      sample();
      e = exp_q.pop_front();
      total++;
      if (bus.out_valid !== 1'b1 || bus.state_out !== e) begin
         bad++;
         $display("FAIL walk_inverse: got v=%b %h want v=1 %h", bus.out_valid, bus.state_out, e);
      end
   endtask

   task automatic test_hold_idle();
      logic [127:0] e;
      drive(1'b0, 1'b1, 1'b0, fwd_in[1]);
      exp_q.push_back(fwd_out[1]);
      sample();
      e = exp_q.pop_front();
      total++;
      if (bus.out_valid !== 1'b1 || bus.state_out !== e) begin
         bad++;
         $display("FAIL hold_load: got v=%b %h want v=1 %h", bus.out_valid, bus.state_out, e);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, i[0], {$urandom, $urandom, $urandom, $urandom});
         sample();
         total++;
         if (bus.out_valid !== 1'b0 || bus.state_out !== e) begin
            bad++;
            $display("FAIL hold_idle_%0d: got v=%b %h want v=0 %h", i, bus.out_valid, bus.state_out, e);
         end
      end
   endtask

   task automatic test_round_trip();
      logic [127:0] orig;
      logic [127:0] mid;
      logic [127:0] e;
      for (int i = 0; i < 1000; i++) begin
         orig = {$urandom, $urandom, $urandom, $urandom};
         mid  = model(orig, 1'b0);
         drive(1'b0, 1'b1, 1'b0, orig);
         exp_q.push_back(mid);
         sample();
         e = exp_q.pop_front();
         total++;
         if (bus.out_valid !== 1'b1 || bus.state_out !== e) begin
            bad++;
            $display("FAIL rt_fwd_%0d: got v=%b %h want v=1 %h", i, bus.out_valid, bus.state_out, e);
         end
         drive(1'b0, 1'b1, 1'b1, mid);
         exp_q.push_back(orig);
         sample();
         e = exp_q.pop_front();
         total++;
         if (bus.out_valid !== 1'b1 || bus.state_out !== e) begin
            bad++;
            $display("FAIL rt_inv_%0d: got v=%b %h want v=1 %h", i, bus.out_valid, bus.state_out, e);
         end
      end
      drive(1'b0, 1'b0, 1'b0, '0);
      sample();
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rt_tail_valid: got %b want 0", bus.out_valid);
      end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.inverse  = 1'b0;
      bus.state_in = '0;
      repeat (3) @(posedge clk);
      test_reset();
      test_forward();
      test_inverse();
      test_byte_walk();
      test_hold_idle();
      test_round_trip();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/aes_shift_rows.md
Name: aes_shift_rows

Overview:
- AES ShiftRows stage (FIPS-197 §5.1.2), with InvShiftRows (§5.3.1) selectable per transfer.
- Pure byte permutation of the 128-bit state, with a single registered output stage.
- Sits between SubBytes and MixColumns in the round datapath; the decryption path uses inverse mode.
- One clock, synchronous active-high reset, valid-qualified input and output.

Parameters:
None.

Ports:
clk        input   1    rising-edge clock
rst        input   1    synchronous reset, active-high
in_valid   input   1    state_in/inverse are valid this cycle
inverse    input   1    0 = ShiftRows, 1 = InvShiftRows; sampled with in_valid
state_in   input   128  input AES state
out_valid  output  1    state_out holds a new result (1-cycle pulse per input)
state_out  output  128  permuted state, registered

Behaviour:
- Byte layout, for both state_in and state_out:
  - Byte k = bits [127-8k : 120-8k], k = 0..15 (byte 0 is the MSB).
  - Column-major: byte k is row r = k mod 4, column c = k div 4, i.e. s[r][c] = byte(4c+r).
- Forward mode (inverse = 0): out s[r][c] = in s[r][(c + r) mod 4].
  - Row 0 unchanged; rows 1, 2, 3 rotate left by 1, 2, 3 bytes.
  - Equivalent byte map, out k <- in: 0←0, 1←5, 2←10, 3←15, 4←4, 5←9, 6←14, 7←3, 8←8, 9←13, 10←2, 11←7, 12←12, 13←1, 14←6, 15←11.
- Inverse mode (inverse = 1): out s[r][c] = in s[r][(c − r) mod 4].
  - Rows rotate right by r bytes.
  - Byte map, out k <- in: 0←0, 1←13, 2←10, 3←7, 4←4, 5←1, 6←14, 7←11, 8←8, 9←5, 10←2, 11←15, 12←12, 13←9, 14←6, 15←3.
- Timing:
  - Latency is exactly 1 clock.
  - On a rising edge with in_valid = 1, state_out <= permute(state_in, inverse) and out_valid <= 1.
  - On a rising edge with in_valid = 0, out_valid <= 0 and state_out holds its previous value.
- Throughput: one state per clock. Back-to-back in_valid cycles are accepted with no bubbles. There is no backpressure and no ready signal.
- Reset:
  - rst = 1 at a rising edge sets state_out <= 128'h0 and out_valid <= 0.
  - Reset has priority over in_valid; an input presented in the same cycle as reset is dropped.
  - A transfer accepted in the cycle before reset asserts is lost if reset arrives before the output is consumed. Its out_valid pulse still occurs unless reset is high on that same edge.
- Involution: forward followed by inverse, on any value, returns the original state.
- The permutation logic is purely combinational wiring feeding the register. No arithmetic is performed and no X propagates from the inverse input when in_valid = 0.

Test Plan:
- Forward vectors, inverse = 0, one per cycle, in_valid held high:
  - d42711aee0bf98f1b8b45de51e415230 → d4bf5d30e0b452aeb84111f11e2798e5
  - 49ded28945db96f17f39871a7702533b → 49db873b453953897f02d2f177de961a
  - ac73cf7befc111df13b5d6b545235ab8 → acc1d6b8efb55a7b1323cfdf457311b5
  - Each result appears 1 cycle later with out_valid = 1 on 3 consecutive cycles.
- Inverse vectors, inverse = 1:
  - d4bf5d30e0b452aeb84111f11e2798e5 → d42711aee0bf98f1b8b45de51e415230
  - acc1d6b8efb55a7b1323cfdf457311b5 → ac73cf7befc111df13b5d6b545235ab8
- Byte-walk: state_in = 000102030405060708090a0b0c0d0e0f.
  - Forward → 00050a0f04090e03080d02070c01060b
  - Inverse → 000d0a0704010e0b0805020f0c090603
- Hold and idle: after one valid transfer, drop in_valid and change state_in for 3 cycles → out_valid = 0 and state_out unchanged.
- Reset: assert rst together with in_valid = 1 → next edge state_out = 0 and out_valid = 0. Release rst, apply the first forward vector → correct result after 1 cycle.
- Random round-trip: 1000 random states, each sent forward, then the forward result sent with inverse = 1 → each recovers the original state exactly.
